// File: rtl/sync_fifo_gen2_if.sv
// Handshake/status bundle for sync_fifo_gen2; signal names match the legacy port list.
interface sync_fifo_gen2_if #(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 1024
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              i_wren;
  logic [DATA_W-1:0] i_wrdata;
  logic              i_rden;
  logic              i_clr_err;
  logic [DATA_W-1:0] o_rddata;
  logic              o_full;
  logic              o_empty;
  logic              o_alm_full;
  logic              o_alm_empty;
  logic [CW-1:0]     o_count;
  logic              o_overflow;
  logic              o_underflow;

  modport master (
    output i_wren, i_wrdata, i_rden, i_clr_err,
    input  o_rddata, o_full, o_empty, o_alm_full, o_alm_empty,
           o_count, o_overflow, o_underflow
  );

  modport slave (
    input  i_wren, i_wrdata, i_rden, i_clr_err,
    output o_rddata, o_full, o_empty, o_alm_full, o_alm_empty,
           o_count, o_overflow, o_underflow
  );
endinterface

// File: rtl/sync_fifo_gen2.sv
// Single-clock FIFO with registered status flags and sticky overflow/underflow.
// Define FIFO_FWFT_EN for first-word-fall-through read data; default is 1-cycle registered read.
module sync_fifo_gen2 #(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 1024,
  parameter int UPP_TH = 4,
  parameter int LOW_TH = 2
) (
  input logic            clk,
  input logic            rstn,
  sync_fifo_gen2_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] AF_LVL = CW'(DEPTH - UPP_TH);
  localparam logic [CW-1:0] AE_LVL = CW'(LOW_TH);
  localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              alm_full_q, alm_full_d;
  logic              alm_empty_q, alm_empty_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              wr_acc, rd_acc;

  always_comb begin
    // Reads never borrow a same-cycle write; writes may use the slot a read frees.
    rd_acc      = bus.i_rden && !empty_q;
    wr_acc      = bus.i_wren && (!full_q || rd_acc);
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    full_d      = (count_d == FULL_LVL);
    empty_d     = (count_d == '0);
    alm_full_d  = (count_d >= AF_LVL);
    alm_empty_d = (count_d <= AE_LVL);
    ovf_d       = (ovf_q && !bus.i_clr_err) || (bus.i_wren && full_q && !rd_acc);
    unf_d       = (unf_q && !bus.i_clr_err) || (bus.i_rden && empty_q);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      alm_full_q  <= 1'b0;
      alm_empty_q <= 1'b1;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      alm_full_q  <= alm_full_d;
      alm_empty_q <= alm_empty_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= bus.i_wrdata;
  end

`ifdef FIFO_FWFT_EN
  assign bus.o_rddata = empty_q ? '0 : mem_q[rd_ptr_q];
`else
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)       rdata_q <= '0;
    else if (rd_acc) rdata_q <= mem_q[rd_ptr_q];
  end

  assign bus.o_rddata = rdata_q;
`endif

  assign bus.o_count     = count_q;
  assign bus.o_full      = full_q;
  assign bus.o_empty     = empty_q;
  assign bus.o_alm_full  = alm_full_q;
  assign bus.o_alm_empty = alm_empty_q;
  assign bus.o_overflow  = ovf_q;
  assign bus.o_underflow = unf_q;
endmodule
